// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: destination-select encodings, instruction
// field positions and the default writeback source indices.
package mips_defs;

  typedef enum logic [1:0] {
    A3_RT   = 2'b00,
    A3_RD   = 2'b01,
    A3_LINK = 2'b10,
    A3_NONE = 2'b11
  } a3_sel_e;

  localparam int INSTR_W  = 32;
  localparam int FIELD_W  = 5;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;

  localparam int SRC_ALU  = 0;
  localparam int SRC_DM   = 1;
  localparam int SRC_PC8  = 2;
  localparam int SRC_TDM  = 3;

endpackage

// File: rtl/wb_select_unit_hilo_regs.sv
// HI/LO register pair with commit-gated writes and write-to-read bypass taps
// for the writeback data path.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wd,
  input  logic [WIDTH-1:0] lo_wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_fwd,
  output logic [WIDTH-1:0] lo_fwd
);

  logic [WIDTH-1:0] hi_d, hi_q;
  logic [WIDTH-1:0] lo_d, lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && hi_we) hi_d = hi_wd;
    if (commit && lo_we) lo_d = lo_wd;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // The bypass only cares whether a write is being presented this cycle; the
  // caller decides whether the selected value is actually consumed.
  assign hi_fwd = hi_we ? hi_wd : hi_q;
  assign lo_fwd = lo_we ? lo_wd : lo_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: rtl/wb_select_unit.sv
// W-stage writeback select: decodes the GRF destination, picks one of NSRC
// result sources (last two are HI/LO) and registers the writeback record.
module wb_select_unit
  import mips_defs::*;
#(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 8,
  parameter int SEL_W    = 3,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [INSTR_W-1:0]    instr,
  input  logic [1:0]            a3_sel,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [WIDTH-1:0]      hi_wd,
  input  logic [WIDTH-1:0]      lo_wd,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [WIDTH-1:0]      wb_data,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo,
  output logic                  sel_err
);

  logic              wb_valid_d, wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_d,  wb_addr_q;
  logic [WIDTH-1:0]  wb_data_d,  wb_data_q;
  logic              sel_err_d,  sel_err_q;

  logic              accept;
  logic              commit;
  logic              sel_oor;
  logic [ADDR_W-1:0] dec_addr;
  logic [WIDTH-1:0]  sel_val;
  logic [WIDTH-1:0]  hi_fwd, lo_fwd;
  logic              unused_bits;

  assign accept  = en && !flush;
  assign commit  = accept && in_valid;
  assign sel_oor = int'(src_sel) >= NSRC;

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk    (clk),
    .reset  (reset),
    .commit (commit),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_wd  (hi_wd),
    .lo_wd  (lo_wd),
    .hi     (hi),
    .lo     (lo),
    .hi_fwd (hi_fwd),
    .lo_fwd (lo_fwd)
  );

  // NOTE: every combinational output gets a default before the case/if chain,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    dec_addr = '0;
    case (a3_sel_e'(a3_sel))
      A3_RT:   dec_addr = ADDR_W'(instr[RT_LSB +: FIELD_W]);
      A3_RD:   dec_addr = ADDR_W'(instr[RD_LSB +: FIELD_W]);
      A3_LINK: dec_addr = ADDR_W'(LINK_REG);
      default: dec_addr = '0;
    endcase
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NSRC - 2; i++) begin
      if (int'(src_sel) == i) sel_val = src_data[i*WIDTH +: WIDTH];
    end
    if (int'(src_sel) == NSRC - 2) sel_val = hi_fwd;
    if (int'(src_sel) == NSRC - 1) sel_val = lo_fwd;
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    sel_err_d  = sel_err_q;
    if (flush) begin
      wb_valid_d = 1'b0;
      wb_addr_d  = '0;
      wb_data_d  = '0;
    end else if (en) begin
      wb_valid_d = in_valid;
      wb_addr_d  = in_valid ? dec_addr : '0;
      wb_data_d  = in_valid ? sel_val  : '0;
      // Bubbles carry meaningless selects, so only real records can flag.
      if (in_valid && sel_oor) sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign sel_err  = sel_err_q;
  assign wb_we    = wb_valid_q && (wb_addr_q != '0);

  // Opcode/funct bits and the ignored HI/LO source slices are deliberately unread.
  assign unused_bits = ^{instr, src_data[NSRC*WIDTH-1 -: 2*WIDTH]};

endmodule

// File: tb/tb_wb_select_unit.sv
// Scoreboard bench for wb_select_unit (NSRC=6): directed vectors push their
// hand-computed records; a negedge monitor pops and compares when due.
module tb_wb_select_unit;
  import mips_defs::*;

  localparam int WIDTH = 32;
  localparam int NSRC  = 6;
  localparam int SEL_W = 3;
  localparam int ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en, flush, in_valid;
  logic [31:0]           instr;
  logic [1:0]            a3_sel;
  logic [SEL_W-1:0]      src_sel;
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  hi_we, lo_we;
  logic [WIDTH-1:0]      hi_wd, lo_wd;
  logic                  wb_valid, wb_we, sel_err;
  logic [ADDR_W-1:0]     wb_addr;
  logic [WIDTH-1:0]      wb_data, hi, lo;

  wb_select_unit #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .instr(instr), .a3_sel(a3_sel), .src_sel(src_sel), .src_data(src_data),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wd(hi_wd), .lo_wd(lo_wd),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hi(hi), .lo(lo), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          due;
    logic        valid;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation stale (due %0d, now %0d)", e.name, e.due, cyc);
      end else begin
        check({e.name, ".wb_valid"}, 32'(wb_valid), 32'(e.valid));
        check({e.name, ".wb_we"},    32'(wb_we),    32'(e.we));
        check({e.name, ".wb_addr"},  32'(wb_addr),  32'(e.addr));
        check({e.name, ".wb_data"},  wb_data,       e.data);
        check({e.name, ".hi"},       hi,            e.hi);
        check({e.name, ".lo"},       lo,            e.lo);
        check({e.name, ".sel_err"},  32'(sel_err),  32'(e.err));
      end
    end
  end

  // Applies one cycle's inputs just after a rising edge.
  task automatic drive(input logic rst, input logic e, input logic fl, input logic iv,
                       input logic [31:0] ins, input logic [1:0] a3, input logic [2:0] ss,
                       input logic hw, input logic lw, input logic [31:0] hd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    reset = rst; en = e; flush = fl; in_valid = iv; instr = ins; a3_sel = a3;
    src_sel = ss; hi_we = hw; lo_we = lw; hi_wd = hd; lo_wd = ld;
  endtask

  task automatic expect_rec(input string name, input logic v, input logic w, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] h, input logic [31:0] l,
                            input logic er);
    exp_t e;
    e.name = name; e.due = cyc + 1; e.valid = v; e.we = w; e.addr = a;
    e.data = d; e.hi = h; e.lo = l; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic set_src(input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3);
    src_data = {32'hF00D_F00D, 32'hBAD0_BAD0, s3, s2, s1, s0};
  endtask

  initial begin
    int budget;
    reset = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; a3_sel = '0;
    src_sel = '0; hi_we = 1'b0; lo_we = 1'b0; hi_wd = '0; lo_wd = '0; src_data = '0;

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 2'($urandom), 3'($urandom_range(0, 5)),
            1'b1, 1'b1, $urandom, $urandom);
      src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expect_rec("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    end

    set_src(32'h0000_1234, 32'h0000_0055, 32'h0000_3008, 32'h0000_CAFE);
    drive(1, 1, 0, 1, 32'h0000_2800, A3_RD, 3'(SRC_ALU), 0, 0, 0, 0);
    set_src(32'h0000_1234, 32'h0000_0055, 32'h0000_3008, 32'h0000_CAFE);
    expect_rec("rd_alu", 1, 1, 5, 32'h0000_1234, 0, 0, 0);

    drive(1, 1, 0, 1, 32'hFFFF_FFFF, A3_LINK, 3'(SRC_PC8), 0, 0, 0, 0);
    expect_rec("link_pc8", 1, 1, 31, 32'h0000_3008, 0, 0, 0);

    drive(1, 1, 0, 1, 32'h0000_3800, A3_RT, 3'(SRC_DM), 0, 0, 0, 0);
    expect_rec("rt_zero", 1, 0, 0, 32'h0000_0055, 0, 0, 0);

    drive(1, 1, 0, 1, 32'h0000_1800, A3_RD, 3'(NSRC-2), 1, 1, 32'hAAAA_0000, 32'h0000_BBBB);
    expect_rec("hi_bypass", 1, 1, 3, 32'hAAAA_0000, 32'hAAAA_0000, 32'h0000_BBBB, 0);

    drive(1, 1, 0, 1, 32'h0000_1800, A3_RD, 3'(NSRC-1), 0, 0, 32'h1, 32'h2);
    expect_rec("lo_read", 1, 1, 3, 32'h0000_BBBB, 32'hAAAA_0000, 32'h0000_BBBB, 0);

    drive(1, 1, 0, 1, 32'h0000_1800, A3_RD, 3'(NSRC-1), 0, 1, 32'h1, 32'h0000_0077);
    expect_rec("lo_bypass", 1, 1, 3, 32'h0000_0077, 32'hAAAA_0000, 32'h0000_0077, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 32'h0000_4800, A3_RD, 3'(SRC_ALU), 1, 0, 32'h0000_DEAD, 0);
      set_src(32'h0000_9999 + 32'(i), 32'h1, 32'h2, 32'h3);
      expect_rec("stall", 1, 1, 3, 32'h0000_0077, 32'hAAAA_0000, 32'h0000_0077, 0);
    end

    drive(1, 1, 0, 1, 32'h0000_4800, A3_RD, 3'(SRC_ALU), 1, 0, 32'h0000_DEAD, 0);
    set_src(32'h0000_9999, 32'h1, 32'h2, 32'h0000_CAFE);
    expect_rec("stall_release", 1, 1, 9, 32'h0000_9999, 32'h0000_DEAD, 32'h0000_0077, 0);

    drive(1, 0, 1, 1, 32'h0000_4800, A3_RD, 3'(SRC_ALU), 1, 0, 32'h0000_BEEF, 0);
    expect_rec("flush_stall", 0, 0, 0, 32'h0, 32'h0000_DEAD, 32'h0000_0077, 0);

    drive(1, 1, 0, 0, 32'h0000_4800, A3_RD, 3'(SRC_ALU), 1, 0, 32'h0000_1111, 0);
    expect_rec("bubble", 0, 0, 0, 32'h0, 32'h0000_DEAD, 32'h0000_0077, 0);

    drive(1, 1, 0, 1, 32'h0000_2800, A3_RD, 3'd7, 0, 0, 0, 0);
    expect_rec("oor_7", 1, 1, 5, 32'h0, 32'h0000_DEAD, 32'h0000_0077, 1);

    drive(1, 1, 0, 1, 32'h0000_2800, A3_RD, 3'd6, 0, 0, 0, 0);
    expect_rec("oor_6", 1, 1, 5, 32'h0, 32'h0000_DEAD, 32'h0000_0077, 1);

    drive(1, 1, 0, 1, 32'h0000_2800, A3_NONE, 3'(SRC_TDM), 0, 0, 0, 0);
    expect_rec("err_sticky", 1, 0, 0, 32'h0000_CAFE, 32'h0000_DEAD, 32'h0000_0077, 1);

    drive(1, 1, 1, 1, 32'h0000_2800, A3_RD, 3'(SRC_ALU), 0, 1, 0, 32'h0000_2222);
    expect_rec("flush_en", 0, 0, 0, 32'h0, 32'h0000_DEAD, 32'h0000_0077, 1);

    drive(0, 0, 0, 1, 32'h0000_2800, A3_RD, 3'(SRC_ALU), 1, 1, 32'h5, 32'h6);
    expect_rec("reset_stall", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

    drive(1, 1, 0, 1, 32'h000C_0000, A3_RT, 3'(NSRC-2), 0, 0, 32'h5, 32'h6);
    expect_rec("post_reset_hi", 1, 1, 12, 32'h0, 32'h0, 32'h0, 0);

    drive(1, 0, 0, 0, 0, A3_NONE, 0, 0, 0, 0, 0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
